bsg_rocket_nasti_checker: RTL and testbench

Synthesizable protocol checker and statistics block for one NASTI port (AW, W, B, AR, R). It sits passively beside any client or master NASTI link in the rocket tile/bridge. It counts handshakes per channel, tracks outstanding reads and writes, and checks W burst length against AW len. It also detects handshake-rule violations and stalls, and reports the first error as a sticky code.

---
 rtl/bsg_rocket_pkg.sv | 47 ++++
 rtl/bsg_rocket_nasti_len_fifo.sv | 47 ++++
 rtl/bsg_rocket_nasti_checker.sv | 233 +++++++++++++++++++++++
 tb/tb_bsg_rocket_nasti_checker.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_rocket_pkg.sv
// Shared NASTI payload types, channel indices and checker error codes.
package bsg_rocket_pkg;

    localparam int unsigned bsg_nasti_chans_c     = 5;
    localparam int unsigned bsg_nasti_chan_aw_c   = 0;
    localparam int unsigned bsg_nasti_chan_w_c    = 1;
    localparam int unsigned bsg_nasti_chan_b_c    = 2;
    localparam int unsigned bsg_nasti_chan_ar_c   = 3;
    localparam int unsigned bsg_nasti_chan_r_c    = 4;
    localparam int unsigned bsg_nasti_len_width_c = 8;

    typedef struct packed {
        logic [3:0]                       id;
        logic [31:0]                      addr;
        logic [bsg_nasti_len_width_c-1:0] len;
    } bsg_nasti_a_pkt;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } bsg_nasti_w_pkt;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bsg_nasti_b_pkt;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } bsg_nasti_r_pkt;

    typedef enum logic [3:0] {
        ErrNone          = 4'd0,
        ErrValidDrop     = 4'd1,
        ErrPayloadChange = 4'd2,
        ErrRdUnderflow   = 4'd3,
        ErrWrUnderflow   = 4'd4,
        ErrWNoAw         = 4'd5,
        ErrWLast         = 4'd6,
        ErrOverflow      = 4'd7,
        ErrTimeout       = 4'd8
    } bsg_nasti_err_e;

endpackage

// File: rtl/bsg_rocket_nasti_len_fifo.sv
// Synchronous FIFO of AW burst lengths; when empty, a same-cycle push is forwarded
// straight to the head so a push+pop pair passes through without being stored.
module bsg_rocket_nasti_len_fifo #(
    parameter int unsigned depth_p = 8,
    parameter int unsigned width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               push_i,
    input  logic [width_p-1:0] data_i,
    input  logic               pop_i,
    output logic [width_p-1:0] data_o,
    output logic               empty_o,
    output logic               full_o
);

    localparam int unsigned ptr_w_lp = $clog2(depth_p);

    logic [ptr_w_lp:0]  wptr_q, rptr_q;
    logic [width_p-1:0] mem_q [depth_p];
    logic               bypass, do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[ptr_w_lp] != rptr_q[ptr_w_lp])
                  && (wptr_q[ptr_w_lp-1:0] == rptr_q[ptr_w_lp-1:0]);

    assign bypass  = empty_o & push_i & pop_i;
    assign do_push = push_i & ~full_o & ~bypass;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = empty_o ? data_i : mem_q[rptr_q[ptr_w_lp-1:0]];

    always_ff @(posedge clk_i) begin
        if (!reset_n_i || clear_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[ptr_w_lp-1:0]] <= data_i;
    end

endmodule

// File: rtl/bsg_rocket_nasti_checker.sv
// Passive NASTI protocol checker: per-channel handshake counters, outstanding tracking,
// W burst length check and sticky first-error report. Trace: BSG_ROCKET_NASTI_CHECKER_TRACE_EN.
module bsg_rocket_nasti_checker
    import bsg_rocket_pkg::*;
#(
    parameter int unsigned cnt_width_p = 32,
    parameter int unsigned max_outst_p = 8,
    parameter int unsigned timeout_p   = 1024
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [4:0]                         valid_i,
    input  logic [4:0]                         ready_i,
    input  bsg_nasti_a_pkt                     aw_data_i,
    input  bsg_nasti_w_pkt                     w_data_i,
    input  bsg_nasti_b_pkt                     b_data_i,
    input  bsg_nasti_a_pkt                     ar_data_i,
    input  bsg_nasti_r_pkt                     r_data_i,
    input  logic                               clear_i,
    input  logic [2:0]                         cnt_sel_i,
    output logic [cnt_width_p-1:0]             count_o,
    output logic [$clog2(max_outst_p+1)-1:0]   rd_outst_o,
    output logic [$clog2(max_outst_p+1)-1:0]   wr_outst_o,
    output logic                               error_v_o,
    output logic [3:0]                         error_code_o,
    output logic [2:0]                         error_chan_o
);

    localparam int unsigned outst_w_lp = $clog2(max_outst_p+1);
    localparam int unsigned tmr_w_lp   = (timeout_p > 0) ? $clog2(timeout_p+1) : 1;
    localparam logic [outst_w_lp-1:0] outst_max_lp = outst_w_lp'(max_outst_p);

    logic [4:0] fire, stall_now, stalled_q, changed, timed_out;

    assign fire      = valid_i & ready_i;
    assign stall_now = valid_i & ~ready_i;

    bsg_nasti_a_pkt aw_q, ar_q;
    bsg_nasti_w_pkt w_q;
    bsg_nasti_b_pkt b_q;
    bsg_nasti_r_pkt r_q;

    assign changed[bsg_nasti_chan_aw_c] = (aw_data_i != aw_q);
    assign changed[bsg_nasti_chan_w_c]  = (w_data_i != w_q);
    assign changed[bsg_nasti_chan_b_c]  = (b_data_i != b_q);
    assign changed[bsg_nasti_chan_ar_c] = (ar_data_i != ar_q);
    assign changed[bsg_nasti_chan_r_c]  = (r_data_i != r_q);

    logic [cnt_width_p-1:0]           cnt_q [5];
    logic [tmr_w_lp-1:0]              tmr_q [5];
    logic [tmr_w_lp-1:0]              tmr_d [5];
    logic [outst_w_lp-1:0]            rd_q, rd_d, wr_q, wr_d;
    logic [bsg_nasti_len_width_c-1:0] beat_q, beat_d, head_len;
    logic                             fifo_empty, fifo_full, w_no_len, r_last_fire, w_last_fire;
    logic                             err_v_q;
    bsg_nasti_err_e                   err_code_q, err_sel;
    logic [2:0]                       err_chan_q, chan_sel;
    bsg_nasti_err_e                   spec_err [5];
    bsg_nasti_err_e                   chan_err [5];

    assign r_last_fire = fire[bsg_nasti_chan_r_c] & r_data_i.last;
    assign w_last_fire = fire[bsg_nasti_chan_w_c] & w_data_i.last;
    // A same-cycle AW push supplies the length for a W beat arriving on an empty FIFO.
    assign w_no_len    = fifo_empty & ~fire[bsg_nasti_chan_aw_c];

    bsg_rocket_nasti_len_fifo #(
        .depth_p (max_outst_p),
        .width_p (bsg_nasti_len_width_c)
    ) len_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (clear_i),
        .push_i    (fire[bsg_nasti_chan_aw_c]),
        .data_i    (aw_data_i.len),
        .pop_i     (w_last_fire),
        .data_o    (head_len),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

    always_comb begin
        for (int c = 0; c < 5; c++) begin
            tmr_d[c] = '0;
            if (stall_now[c]) begin
                tmr_d[c] = (tmr_q[c] != tmr_w_lp'(timeout_p)) ? tmr_q[c] + 1'b1 : tmr_q[c];
            end
            timed_out[c] = (timeout_p != 0) && stall_now[c]
                        && (tmr_q[c] == tmr_w_lp'(timeout_p - 1));
        end
    end

    always_comb begin
        rd_d = rd_q;
        if (fire[bsg_nasti_chan_ar_c] && !r_last_fire && rd_q != outst_max_lp) begin
            rd_d = rd_q + 1'b1;
        end else if (r_last_fire && !fire[bsg_nasti_chan_ar_c] && rd_q != '0) begin
            rd_d = rd_q - 1'b1;
        end
        wr_d = wr_q;
        if (fire[bsg_nasti_chan_aw_c] && !fire[bsg_nasti_chan_b_c] && wr_q != outst_max_lp) begin
            wr_d = wr_q + 1'b1;
        end else if (fire[bsg_nasti_chan_b_c] && !fire[bsg_nasti_chan_aw_c] && wr_q != '0) begin
            wr_d = wr_q - 1'b1;
        end
        beat_d = beat_q;
        if (fire[bsg_nasti_chan_w_c]) beat_d = w_data_i.last ? '0 : beat_q + 1'b1;
    end

    // Channel-specific errors, then the generic stall checks, then pick the lowest channel.
    always_comb begin
        for (int c = 0; c < 5; c++) spec_err[c] = ErrNone;
        if (r_last_fire && rd_q == '0) spec_err[bsg_nasti_chan_r_c] = ErrRdUnderflow;
        if (fire[bsg_nasti_chan_b_c] && wr_q == '0) spec_err[bsg_nasti_chan_b_c] = ErrWrUnderflow;
        if (fire[bsg_nasti_chan_w_c]) begin
            if (w_no_len) begin
                spec_err[bsg_nasti_chan_w_c] = ErrWNoAw;
            end else if (w_data_i.last != (beat_q == head_len)) begin
                spec_err[bsg_nasti_chan_w_c] = ErrWLast;
            end
        end
        if (fire[bsg_nasti_chan_ar_c] && rd_q == outst_max_lp) begin
            spec_err[bsg_nasti_chan_ar_c] = ErrOverflow;
        end
        if (fire[bsg_nasti_chan_aw_c] && wr_q == outst_max_lp) begin
            spec_err[bsg_nasti_chan_aw_c] = ErrOverflow;
        end

        for (int c = 0; c < 5; c++) begin
            if (stalled_q[c] && !valid_i[c])  chan_err[c] = ErrValidDrop;
            else if (stalled_q[c] && changed[c]) chan_err[c] = ErrPayloadChange;
            else if (spec_err[c] != ErrNone)  chan_err[c] = spec_err[c];
            else if (timed_out[c])            chan_err[c] = ErrTimeout;
            else                              chan_err[c] = ErrNone;
        end

        err_sel  = ErrNone;
        chan_sel = '0;
        for (int i = 0; i < 5; i++) begin
            if (chan_err[4-i] != ErrNone) begin
                err_sel  = chan_err[4-i];
                chan_sel = 3'(4 - i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i || clear_i) begin
            stalled_q  <= '0;
            aw_q       <= '0;
            w_q        <= '0;
            b_q        <= '0;
            ar_q       <= '0;
            r_q        <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            beat_q     <= '0;
            err_v_q    <= 1'b0;
            err_code_q <= ErrNone;
            err_chan_q <= '0;
            for (int c = 0; c < 5; c++) begin
                cnt_q[c] <= '0;
                tmr_q[c] <= '0;
            end
        end else begin
            stalled_q <= stall_now;
            if (stall_now[bsg_nasti_chan_aw_c] && !stalled_q[bsg_nasti_chan_aw_c]) aw_q <= aw_data_i;
            if (stall_now[bsg_nasti_chan_w_c]  && !stalled_q[bsg_nasti_chan_w_c])  w_q  <= w_data_i;
            if (stall_now[bsg_nasti_chan_b_c]  && !stalled_q[bsg_nasti_chan_b_c])  b_q  <= b_data_i;
            if (stall_now[bsg_nasti_chan_ar_c] && !stalled_q[bsg_nasti_chan_ar_c]) ar_q <= ar_data_i;
            if (stall_now[bsg_nasti_chan_r_c]  && !stalled_q[bsg_nasti_chan_r_c])  r_q  <= r_data_i;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            beat_q <= beat_d;
            for (int c = 0; c < 5; c++) begin
                tmr_q[c] <= tmr_d[c];
                if (fire[c] && cnt_q[c] != '1) cnt_q[c] <= cnt_q[c] + 1'b1;
            end
            if (!err_v_q && err_sel != ErrNone) begin
                err_v_q    <= 1'b1;
                err_code_q <= err_sel;
                err_chan_q <= chan_sel;
            end
        end
    end

    always_comb begin
        count_o = '0;
        case (cnt_sel_i)
            3'd0:    count_o = cnt_q[0];
            3'd1:    count_o = cnt_q[1];
            3'd2:    count_o = cnt_q[2];
            3'd3:    count_o = cnt_q[3];
            3'd4:    count_o = cnt_q[4];
            default: count_o = '0;
        endcase
    end

    assign rd_outst_o   = rd_q;
    assign wr_outst_o   = wr_q;
    assign error_v_o    = err_v_q;
    assign error_code_o = err_code_q;
    assign error_chan_o = err_chan_q;

`ifdef BSG_ROCKET_NASTI_CHECKER_TRACE_EN
    logic [31:0] cycle_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) cycle_q <= '0;
        else            cycle_q <= cycle_q + 1'b1;
    end

    always @(posedge clk_i) begin
        if (reset_n_i && !clear_i) begin
            if (fire[bsg_nasti_chan_aw_c])
                $display("AW id=%h addr=%h len=%0d",
                         aw_data_i.id, aw_data_i.addr, aw_data_i.len);
            if (fire[bsg_nasti_chan_w_c])
                $display("W data=%h last=%0d", w_data_i.data, w_data_i.last);
            if (fire[bsg_nasti_chan_b_c])
                $display("B id=%h resp=%0d", b_data_i.id, b_data_i.resp);
            if (fire[bsg_nasti_chan_ar_c])
                $display("AR id=%h addr=%h len=%0d",
                         ar_data_i.id, ar_data_i.addr, ar_data_i.len);
            if (fire[bsg_nasti_chan_r_c])
                $display("R id=%h data=%h resp=%0d last=%0d",
                         r_data_i.id, r_data_i.data, r_data_i.resp, r_data_i.last);
            if (!err_v_q && err_sel != ErrNone)
                $display("NASTI_ERR %0d %0d %0d", err_sel, chan_sel, cycle_q);
        end
    end
`endif

endmodule

// File: tb/tb_bsg_rocket_nasti_checker.sv
// Directed self-checking bench for bsg_rocket_nasti_checker (max_outst_p=8, timeout_p=16).
module tb_bsg_rocket_nasti_checker;
    import bsg_rocket_pkg::*;

    logic           clk;
    logic           reset_n;
    logic [4:0]     valid, ready;
    bsg_nasti_a_pkt aw, ar;
    bsg_nasti_w_pkt w;
    bsg_nasti_b_pkt b;
    bsg_nasti_r_pkt r;
    logic           clear;
    logic [2:0]     cnt_sel;
    logic [31:0]    count;
    logic [3:0]     rd_outst, wr_outst;
    logic           err_v;
    logic [3:0]     err_code;
    logic [2:0]     err_chan;

    int checks = 0;
    int errors = 0;

    bsg_rocket_nasti_checker #(
        .cnt_width_p (32),
        .max_outst_p (8),
        .timeout_p   (16)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .valid_i      (valid),
        .ready_i      (ready),
        .aw_data_i    (aw),
        .w_data_i     (w),
        .b_data_i     (b),
        .ar_data_i    (ar),
        .r_data_i     (r),
        .clear_i      (clear),
        .cnt_sel_i    (cnt_sel),
        .count_o      (count),
        .rd_outst_o   (rd_outst),
        .wr_outst_o   (wr_outst),
        .error_v_o    (err_v),
        .error_code_o (err_code),
        .error_chan_o (err_chan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sel_count(input logic [2:0] s);
        cnt_sel = s;
        #1;
    endtask

    task automatic pulse_clear();
        valid = '0;
        ready = '0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        valid = '0; ready = '0; clear = 1'b0; cnt_sel = '0;
        aw = '0; ar = '0; w = '0; b = '0; r = '0;
        tick(); tick();
        reset_n = 1'b1;
        chk("reset_count", count, 0);
        chk("reset_rd", rd_outst, 0);
        chk("reset_wr", wr_outst, 0);
        chk("reset_err_v", err_v, 0);
        chk("reset_code", err_code, 0);

        // Three reads in, three single-beat reads out.
        valid[3] = 1'b1; ready[3] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ar.id = 4'(i); ar.addr = 32'h1000 + 32'(i) * 64;
            tick();
            chk("rd_up", rd_outst, i + 1);
        end
        valid[3] = 1'b0; ready[3] = 1'b0;
        valid[4] = 1'b1; ready[4] = 1'b1; r.last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r.data = 64'(i);
            tick();
            chk("rd_down", rd_outst, 2 - i);
        end
        valid = '0; ready = '0;
        sel_count(3); chk("count_ar", count, 3);
        sel_count(4); chk("count_r", count, 3);
        chk("reads_no_err", err_v, 0);

        // AW len=3 followed by a correct 4-beat burst.
        aw.len = 8'd3; valid[0] = 1'b1; ready[0] = 1'b1;
        tick();
        valid[0] = 1'b0; ready[0] = 1'b0;
        chk("wr_after_aw", wr_outst, 1);
        valid[1] = 1'b1; ready[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w.data = 64'(i); w.last = (i == 3);
            tick();
        end
        valid[1] = 1'b0; ready[1] = 1'b0;
        chk("burst_ok_err_v", err_v, 0);
        sel_count(1); chk("count_w", count, 4);
        valid[2] = 1'b1; ready[2] = 1'b1;
        tick();
        valid[2] = 1'b0; ready[2] = 1'b0;
        chk("wr_after_b", wr_outst, 0);

        // Same length, last asserted one beat early.
        aw.len = 8'd3; valid[0] = 1'b1; ready[0] = 1'b1;
        tick();
        valid[0] = 1'b0; ready[0] = 1'b0;
        valid[1] = 1'b1; ready[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w.last = (i == 2);
            tick();
            chk("early_last_err_v", err_v, (i == 2) ? 1 : 0);
        end
        valid[1] = 1'b0; ready[1] = 1'b0;
        chk("early_last_code", err_code, 6);
        chk("early_last_chan", err_chan, 1);
        pulse_clear();
        chk("clear_err_v", err_v, 0);
        chk("clear_code", err_code, 0);
        chk("clear_count_w", count, 0);
        chk("clear_wr", wr_outst, 0);

        // AR payload changes while stalled, then valid drops.
        valid[3] = 1'b1; ready[3] = 1'b0; ar.addr = 32'h2000;
        tick();
        chk("ar_stall1_err_v", err_v, 0);
        ar.addr = 32'h2004;
        tick();
        chk("ar_change_err_v", err_v, 1);
        chk("ar_change_code", err_code, 2);
        chk("ar_change_chan", err_chan, 3);
        valid[3] = 1'b0;
        tick();
        chk("ar_drop_keeps_code", err_code, 2);
        chk("ar_drop_keeps_chan", err_chan, 3);
        pulse_clear();

        // Nine writes with no response: the ninth overflows.
        aw.len = 8'd0; valid[0] = 1'b1; ready[0] = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("wr_full", wr_outst, 8);
        chk("wr_full_err_v", err_v, 0);
        tick();
        valid[0] = 1'b0; ready[0] = 1'b0;
        chk("ovf_err_v", err_v, 1);
        chk("ovf_code", err_code, 7);
        chk("ovf_chan", err_chan, 0);
        chk("ovf_wr_hold", wr_outst, 8);
        pulse_clear();

        // R held valid without ready for the full timeout window.
        valid[4] = 1'b1; ready[4] = 1'b0; r.last = 1'b0; r.data = 64'hABCD;
        for (int i = 0; i < 15; i++) tick();
        chk("tmo_before_err_v", err_v, 0);
        tick();
        chk("tmo_err_v", err_v, 1);
        chk("tmo_code", err_code, 8);
        chk("tmo_chan", err_chan, 4);
        pulse_clear();
        sel_count(0);
        chk("clr_err_v", err_v, 0);
        chk("clr_code", err_code, 0);
        chk("clr_chan", err_chan, 0);
        chk("clr_rd", rd_outst, 0);
        chk("clr_count", count, 0);

        // Same-cycle AW (len=0) and W last on an empty FIFO.
        aw.len = 8'd0; w.last = 1'b1;
        valid[0] = 1'b1; ready[0] = 1'b1; valid[1] = 1'b1; ready[1] = 1'b1;
        tick();
        valid = '0; ready = '0;
        chk("bypass_err_v", err_v, 0);
        chk("bypass_wr", wr_outst, 1);
        // A lone W now finds the FIFO empty.
        valid[1] = 1'b1; ready[1] = 1'b1; w.last = 1'b1;
        tick();
        valid = '0; ready = '0;
        chk("empty_w_code", err_code, 5);
        chk("empty_w_chan", err_chan, 1);

        // Reset in the middle of a burst, then a fresh clean burst.
        aw.len = 8'd3; valid[0] = 1'b1; ready[0] = 1'b1;
        tick();
        valid[0] = 1'b0; ready[0] = 1'b0;
        valid[1] = 1'b1; ready[1] = 1'b1; w.last = 1'b0;
        tick(); tick();
        valid = '0; ready = '0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        sel_count(1);
        chk("rst_err_v", err_v, 0);
        chk("rst_code", err_code, 0);
        chk("rst_wr", wr_outst, 0);
        chk("rst_count_w", count, 0);
        aw.len = 8'd1; valid[0] = 1'b1; ready[0] = 1'b1;
        tick();
        valid[0] = 1'b0; ready[0] = 1'b0;
        valid[1] = 1'b1; ready[1] = 1'b1;
        w.last = 1'b0; tick();
        w.last = 1'b1; tick();
        valid = '0; ready = '0;
        chk("fresh_err_v", err_v, 0);
        chk("fresh_count_w", count, 2);
        sel_count(0); chk("fresh_count_aw", count, 1);
        valid[2] = 1'b1; ready[2] = 1'b1;
        tick();
        valid = '0; ready = '0;
        chk("fresh_wr", wr_outst, 0);
        sel_count(2); chk("fresh_count_b", count, 1);
        sel_count(5); chk("sel5_zero", count, 0);
        chk("final_err_v", err_v, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
